scan_sel_gen: RTL
=================

# scan_sel_gen

Sequencer that generates the 2-bit channel select (`sel_a`, `sel_b`) feeding the 2-to-4 gate-level decoder, one stage directly upstream of it. On `start` it steps through the enabled channels 0..3 in ascending order, holding each for a programmable dwell time. It runs either one pass or continuously, and flags valid, step, busy and done so downstream logic can qualify the decoder's one-hot outputs.

## Interface
- `DIV_W`, default 8: width of the dwell-period counter.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `en`  in  1  run enable; low freezes the state, counter and all outputs.
- `start`  in  1  begin a scan; acted on only in IDLE with `en`=1.
- `stop`  in  1  abort the scan; return to IDLE.
- `mode`  in  1  0 = continuous wrap; 1 = single pass.
- `period`  in  DIV_W  dwell length minus 1, in cycles per channel.
- `skip_mask`  in  4  bit i = 1 skips channel i.
- `sel_a`  out  1  channel index bit 0; drives decoder input `a`.
- `sel_b`  out  1  channel index bit 1; drives decoder input `b`.
- `sel_valid`  out  1  the current select is live.
- `step`  out  1  one-cycle pulse when a dwell begins.
- `busy`  out  1  high in SCAN.
- `done`  out  1  one-cycle pulse at the end of a pass (single mode) or when the scan is empty.

## Operation
- States: IDLE, SCAN.
- Reset (`rst_n`=0 at a clock edge):
  - state goes to IDLE.
  - `sel_a`, `sel_b`, `sel_valid`, `step`, `busy` and `done` are all 0.
  - The dwell counter and the captured registers are cleared to 0.
- IDLE, on `start`=1, `en`=1, `stop`=0:
  - `period`, `mode` and `skip_mask` are captured. Later input changes have no effect until the next start.
  - If the captured mask is 4'b1111: stay in IDLE and pulse `done` next cycle. `sel_valid` and `busy` stay 0.
  - Otherwise go to SCAN. The select becomes the lowest enabled index, the counter is set to 0, and `sel_valid`, `busy` and `step` go to 1.
- SCAN, with `en`=1:
  - While the counter is below the captured period, the counter increments.
  - When the counter equals the period, the dwell ends and the next action depends on mode.
  - Next enabled index above the current one exists: move to it, set the counter to 0, pulse `step`.
  - No higher enabled index, continuous mode: wrap to the lowest enabled index, set the counter to 0, pulse `step`. This applies even when that index is the same channel.
  - No higher enabled index, single-pass mode: go to IDLE, pulse `done`, set `sel_valid` and `busy` to 0, and set the select to 0.
- `stop`=1 (any state, `en` ignored): next cycle state is IDLE and the select, `sel_valid` and `busy` are 0. No `done` pulse is produced.
- Priorities:
  - Reset over `stop`.
  - `stop` over `start` and over dwell advance.
  - `start` in SCAN is ignored.
- `en`=0: every register holds its value. `step` and `done` are forced to 0 that cycle; the pulse is not replayed.
- The select is registered. `{sel_b, sel_a}` equals the channel index; it is 0 in IDLE.

## Timing
- Start latency is 1 cycle. `start` sampled at edge T gives the first select, `sel_valid`, `busy` and `step` valid after edge T+1.
- Each channel is held for exactly `period`+1 enabled cycles. With `period`=0 the select changes every cycle.
- Single pass with k enabled channels: `busy` is high for k·(`period`+1) cycles.
- `done` is asserted in the cycle immediately after the last dwell. In that same cycle `busy`=0 and `sel_valid`=0.
- A new `start` is accepted in the cycle `done` is high, so passes can run back-to-back.
- `step` and `done` are never high for more than 1 cycle per event.

## Test plan
- Reset, then single pass: `rst_n` low 2 cycles with all outputs checked at 0. Then `mode`=1, `period`=2, `skip_mask`=0, `start`.
  - Select sequence is 0,0,0,1,1,1,2,2,2,3,3,3.
  - `step` pulses at cycles 1,4,7,10.
  - `done` at cycle 13, with `busy` low at 13.
- Skip and continuous wrap: `mode`=0, `period`=1, `skip_mask`=4'b0101.
  - Select repeats 1,1,3,3,1,1,3,3,…
  - `done` never asserts.
  - Changing `skip_mask` mid-scan has no effect.
- Boundary cases:
  - All channels skipped: `start` gives a `done` pulse 1 cycle later, `sel_valid` stays 0, `busy` stays 0.
  - Single channel 2 enabled, continuous, `period`=0: select stays at 2 and `step` is high every cycle.
- `en` freeze: `period`=3, drop `en` for 5 cycles in the middle of the channel-1 dwell.
  - Select, counter and `busy` hold.
  - The dwell resumes with its remaining cycles, for 4 enabled cycles total.
- `stop` and `start` in the same cycle during SCAN: next cycle is IDLE with select 0 and no `done`. A fresh `start` afterwards restarts from the lowest enabled channel.
- `rst_n` asserted in the middle of a scan: after the next edge all outputs are 0 and the state is IDLE. `start` during SCAN has no effect.

Source files
------------

// File: rtl/scan_sel_gen.sv
// Channel-select sequencer for the 2-to-4 decoder: steps through enabled
// channels 0..3 with a programmable dwell, single pass or continuous.
module scan_sel_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [DIV_W-1:0] period,
  input  logic [3:0]       skip_mask,
  output logic             sel_a,
  output logic             sel_b,
  output logic             sel_valid,
  output logic             step,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | no scan running; select held at 0
  // SCAN  | dwelling on sel_q, counting cnt_q up to per_q
  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic             mode_q, mode_d;
  logic [3:0]       mask_q, mask_d;

  logic [1:0]       first_idx;
  logic [2:0]       next_info;

  function automatic logic [1:0] lowest_idx(input logic [3:0] mask);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!mask[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // {found, index} of the lowest enabled channel strictly above cur
  function automatic logic [2:0] next_idx(input logic [3:0] mask, input logic [1:0] cur);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!mask[i] && (i > int'(cur))) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

  assign first_idx = lowest_idx(mask_q);
  assign next_info = next_idx(mask_q, sel_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    step_d  = 1'b0;
    done_d  = 1'b0;

    if (stop) begin
      state_d = IDLE;
      sel_d   = 2'd0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            per_d  = period;
            mode_d = mode;
            mask_d = skip_mask;
            if (skip_mask == 4'b1111) begin
              done_d = 1'b1;
            end else begin
              state_d = SCAN;
              sel_d   = lowest_idx(skip_mask);
              cnt_d   = '0;
              valid_d = 1'b1;
              busy_d  = 1'b1;
              step_d  = 1'b1;
            end
          end
        end
        SCAN: begin
          if (cnt_q != per_q) begin
            cnt_d = cnt_q + DIV_W'(1);
          end else if (next_info[2]) begin
            sel_d  = next_info[1:0];
            cnt_d  = '0;
            step_d = 1'b1;
          end else if (!mode_q) begin
            sel_d  = first_idx;
            cnt_d  = '0;
            step_d = 1'b1;
          end else begin
            state_d = IDLE;
            sel_d   = 2'd0;
            cnt_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      per_q   <= '0;
      mode_q  <= 1'b0;
      mask_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
    end
  end

  assign sel_a     = sel_q[0];
  assign sel_b     = sel_q[1];
  assign sel_valid = valid_q;
  assign step      = step_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
